alu: RTL and testbench

//   Registered WIDTH-bit arithmetic/logic unit: ADD, SUB, AND, OR selected by a 2-bit opcode.

---
 rtl/alu_if.sv | 25 ++
 rtl/alu.sv | 111 +++++++++++
 tb/tb_alu.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/alu_if.sv
// ALU bus interface: operation launch (in_valid/A/B/OP) and registered result
// (R/CF/out_valid/ZF/VF). The master drives operands; the slave is the ALU.
interface alu_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [1:0]       OP;
  logic [WIDTH-1:0] R;
  logic             CF;
  logic             out_valid;
  logic             ZF;
  logic             VF;

  modport master (
    output in_valid, A, B, OP,
    input  R, CF, out_valid, ZF, VF
  );

  modport slave (
    input  in_valid, A, B, OP,
    output R, CF, out_valid, ZF, VF
  );
endinterface

// File: rtl/alu.sv
// Registered WIDTH-bit ALU (ADD, SUB, AND, OR) with carry/borrow flag and a
// one-cycle out_valid pulse per launched operation. Latency is one clock.
// Optional zero/overflow flags are built only when ALU_FLAGS_EN is defined;
// otherwise ZF and VF are tied to 0.
module alu #(
  parameter int WIDTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  alu_if.slave  bus
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] r_d;
  logic             cf_d;
  logic [WIDTH-1:0] r_q;
  logic             cf_q;
  logic             valid_q;

  // All four results are formed in parallel; the opcode selects one.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    r_d  = '0;
    cf_d = 1'b0;
    // Zero-extended operands: the extra MSB is the carry (ADD) or, because
    // the subtraction wraps negative exactly when A < B, the borrow (SUB).
    sum  = {1'b0, bus.A} + {1'b0, bus.B};
    diff = {1'b0, bus.A} - {1'b0, bus.B};
    case (op_e'(bus.OP))
      OP_ADD: begin
        r_d  = sum[WIDTH-1:0];
        cf_d = sum[WIDTH];
      end
      OP_SUB: begin
        r_d  = diff[WIDTH-1:0];
        cf_d = diff[WIDTH];
      end
      OP_AND: r_d = bus.A & bus.B;
      OP_OR:  r_d = bus.A | bus.B;
      default: ;
    endcase
  end

  // Result register: loads on in_valid, holds otherwise; reset clears all.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      r_q     <= '0;
      cf_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        r_q  <= r_d;
        cf_q <= cf_d;
      end
    end
  end

  assign bus.R         = r_q;
  assign bus.CF        = cf_q;
  assign bus.out_valid = valid_q;

`ifdef ALU_FLAGS_EN
  logic zf_d;
  logic vf_d;
  logic zf_q;
  logic vf_q;

  // Zero and signed-overflow flags derived from the selected result.
  always_comb begin
    zf_d = (r_d == '0);
    vf_d = 1'b0;
    case (op_e'(bus.OP))
      OP_ADD: vf_d = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                     (r_d[WIDTH-1] != bus.A[WIDTH-1]);
      OP_SUB: vf_d = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                     (r_d[WIDTH-1] != bus.A[WIDTH-1]);
      default: vf_d = 1'b0;
    endcase
  end

  // Flag register shares the load/hold/reset behaviour of the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      zf_q <= 1'b0;
      vf_q <= 1'b0;
    end else if (bus.in_valid) begin
      zf_q <= zf_d;
      vf_q <= vf_d;
    end
  end

  assign bus.ZF = zf_q;
  assign bus.VF = vf_q;
`else
  assign bus.ZF = 1'b0;
  assign bus.VF = 1'b0;
`endif

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu (WIDTH=4). Inputs change on the falling edge;
// outputs are sampled on the falling edge after the launching rising edge.
module tb_alu;

  localparam int W = 4;
`ifdef ALU_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  alu_if #(.WIDTH(W)) bus ();

  alu #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] r;
    logic       cf;
    logic       zf;
    logic       vf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op,
                       input logic [3:0] a, input logic [3:0] b);
    bus.in_valid = v;
    bus.OP       = op;
    bus.A        = a;
    bus.B        = b;
  endtask

  task automatic check_result(input vec_t v);
    check({v.tag, ".R"},  32'(bus.R), 32'(v.r));
    check({v.tag, ".CF"}, 32'(bus.CF), 32'(v.cf));
    check({v.tag, ".ov"}, 32'(bus.out_valid), 32'd1);
    check({v.tag, ".ZF"}, 32'(bus.ZF), FLAGS ? 32'(v.zf) : 32'd0);
    check({v.tag, ".VF"}, 32'(bus.VF), FLAGS ? 32'(v.vf) : 32'd0);
  endtask

  logic [3:0] held_r;
  logic       held_cf;

  initial begin
    //          tag          op     a        b        r        cf    zf    vf
    vecs.push_back('{"add1",  2'b00, 4'b0100, 4'b0011, 4'b0111, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"add2",  2'b00, 4'b1111, 4'b1111, 4'b1110, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{"sub1",  2'b01, 4'b1000, 4'b0010, 4'b0110, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{"sub2",  2'b01, 4'b1001, 4'b0100, 4'b0101, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{"sub3",  2'b01, 4'b0010, 4'b0101, 4'b1101, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{"and1",  2'b10, 4'b0111, 4'b0101, 4'b0101, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"or1",   2'b11, 4'b0110, 4'b1001, 4'b1111, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"addvf", 2'b00, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{"subzf", 2'b01, 4'b0101, 4'b0101, 4'b0000, 1'b0, 1'b1, 1'b0});

    // Reset state.
    rst = 1'b1;
    drive(1'b0, 2'b00, 4'h0, 4'h0);
    repeat (2) @(negedge clk);
    check("rst.R",  32'(bus.R), 32'd0);
    check("rst.CF", 32'(bus.CF), 32'd0);
    check("rst.ov", 32'(bus.out_valid), 32'd0);
    check("rst.ZF", 32'(bus.ZF), 32'd0);
    check("rst.VF", 32'(bus.VF), 32'd0);
    rst = 1'b0;

    // Single operations with an idle cycle between them: one-cycle pulse.
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      @(negedge clk);
      drive(1'b0, 2'b10, 4'hA, 4'h5);
      check_result(vecs[i]);
      @(negedge clk);
      check({vecs[i].tag, ".pulse"}, 32'(bus.out_valid), 32'd0);
    end

    // Back-to-back launches: one result per cycle.
    @(negedge clk);
    drive(1'b1, vecs[0].op, vecs[0].a, vecs[0].b);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      check_result(vecs[i-1]);
    end
    @(negedge clk);
    drive(1'b0, 2'b00, 4'h3, 4'hC);
    check_result(vecs[3]);

    // Hold: in_valid low for three cycles with changing operands.
    held_r  = vecs[3].r;
    held_cf = vecs[3].cf;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b0, 2'(i), 4'(i + 7), 4'(15 - i));
      check($sformatf("hold%0d.R", i),  32'(bus.R), 32'(held_r));
      check($sformatf("hold%0d.CF", i), 32'(bus.CF), 32'(held_cf));
      check($sformatf("hold%0d.ov", i), 32'(bus.out_valid), 32'd0);
    end

    // Load a nonzero result with CF=1, then reset on the same edge as a launch.
    @(negedge clk);
    drive(1'b1, vecs[1].op, vecs[1].a, vecs[1].b);
    @(negedge clk);
    check_result(vecs[1]);
    rst = 1'b1;
    drive(1'b1, 2'b00, 4'b0100, 4'b0011);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 2'b00, 4'h0, 4'h0);
    check("rstwin.R",  32'(bus.R), 32'd0);
    check("rstwin.CF", 32'(bus.CF), 32'd0);
    check("rstwin.ov", 32'(bus.out_valid), 32'd0);
    check("rstwin.ZF", 32'(bus.ZF), 32'd0);

    // Mid-stream reset discards an op launched on the previous edge.
    drive(1'b1, vecs[6].op, vecs[6].a, vecs[6].b);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 2'b00, 4'h0, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    check("midrst.R",  32'(bus.R), 32'd0);
    check("midrst.ov", 32'(bus.out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
